// File: rtl/top_proj.sv
// DIP switch 1 to LED 1 bridge: two-flop synchroniser, debounce, and a wrapping count of accepted level changes.
// Latency: DEBOUNCE_CYCLES+2 clocks from the first sampling edge to the LED change.
// Backpressure: none; the input is sampled every clock, and glitches shorter than DEBOUNCE_CYCLES are dropped.
module top_proj #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GPIO_DIP1,
  output logic       GPIO_LED1,
  output logic [7:0] dip_edges
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          state;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised cycles that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= 1'b0;
      cnt       <= '0;
      dip_edges <= 8'd0;
    end else begin
      sync1 <= GPIO_DIP1;
      sync2 <= sync1;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state     <= sync2;
        cnt       <= '0;
        dip_edges <= dip_edges + 8'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign GPIO_LED1 = state;

endmodule

// File: tb/tb_top_proj.sv
// Bench for top_proj: DEBOUNCE_CYCLES=4 and =1 instances share one switch input and are checked against a run-length reference model.
module tb_top_proj;

  logic       clk;
  logic       rst;
  logic       dip;
  logic       led_a, led_b;
  logic [7:0] edges_a, edges_b;

  int checks   = 0;
  int failures = 0;

  top_proj #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .GPIO_DIP1(dip), .GPIO_LED1(led_a), .dip_edges(edges_a)
  );
  top_proj #(.DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .GPIO_DIP1(dip), .GPIO_LED1(led_b), .dip_edges(edges_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a two-sample delay line, then the LED flips whenever the last d delayed samples since reset all disagree with it.
  logic        p1[2];
  logic        p2[2];
  logic        mled[2];
  logic [7:0]  medges[2];
  logic [63:0] hist[2];
  int          nsince[2];

  task automatic model_step(input int i, input int d, input logic r, input logic din);
    logic [63:0] mask;
    mask = (64'd1 << d) - 64'd1;
    if (r) begin
      p1[i] = 1'b0; p2[i] = 1'b0; mled[i] = 1'b0; medges[i] = 8'd0;
      hist[i] = 64'd0; nsince[i] = 0;
    end else begin
      hist[i] = {hist[i][62:0], p2[i]};
      nsince[i] = nsince[i] + 1;
      if (nsince[i] >= d && ((hist[i] & mask) == (mled[i] ? 64'd0 : mask))) begin
        mled[i] = ~mled[i];
        medges[i] = medges[i] + 8'd1;
      end
      p2[i] = p1[i];
      p1[i] = din;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r, dv;
    r  = rst;
    dv = dip;
    @(posedge clk);
    model_step(0, 4, r, dv);
    model_step(1, 1, r, dv);
    @(negedge clk);
    chk("led_d4", led_a, mled[0]);
    chk("edges_d4", edges_a, medges[0]);
    chk("led_d1", led_b, mled[1]);
    chk("edges_d1", edges_b, medges[1]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic measure_rise(output int lat_a, output int lat_b);
    lat_a = -1;
    lat_b = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (lat_a < 0 && led_a === 1'b1) lat_a = k;
      if (lat_b < 0 && led_b === 1'b1) lat_b = k;
    end
  endtask

  initial begin
    int         la, lb, hi_cnt;
    logic [7:0] e0, e1;

    // Reset held for 3 cycles with the switch already high.
    rst = 1'b1;
    dip = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_led", led_a, 0);
      chk("rst_edges", edges_a, 0);
    end
    rst = 1'b0;
    measure_rise(la, lb);
    chk("rise_after_rst_d4", la, 6);
    chk("rise_after_rst_d1", lb, 3);
    chk("edges_after_rst", edges_a, 1);

    // Toggling every 100 ns starting from LED off.
    dip = 1'b0;
    ticks(12);
    e0 = edges_a;
    for (int ph = 0; ph < 11; ph++) begin
      dip = (ph >= 2) ? ((ph % 2) == 0) : 1'b0;
      ticks(10);
    end
    e1 = e0 + 8'd9;
    chk("toggle_edges", edges_a, e1);

    // Glitch rejection: a 3-cycle pulse is dropped, a 4-cycle pulse passes.
    dip = 1'b0;
    ticks(12);
    e0 = edges_a;
    hi_cnt = 0;
    dip = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); if (led_a === 1'b1) hi_cnt++; end
    dip = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); if (led_a === 1'b1) hi_cnt++; end
    chk("glitch3_led_high", hi_cnt, 0);
    chk("glitch3_edges", edges_a, e0);
    hi_cnt = 0;
    dip = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); if (led_a === 1'b1) hi_cnt++; end
    dip = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); if (led_a === 1'b1) hi_cnt++; end
    chk("pulse4_led_high", hi_cnt, 4);
    e1 = e0 + 8'd2;
    chk("pulse4_edges", edges_a, e1);

    // Reset 3 cycles into a debounce restarts the full latency.
    dip = 1'b1;
    ticks(3);
    rst = 1'b1;
    tick();
    chk("mid_rst_led", led_a, 0);
    rst = 1'b0;
    measure_rise(la, lb);
    chk("mid_rst_lat_d4", la, 6);
    chk("mid_rst_lat_d1", lb, 3);

    // 256 accepted toggles wrap the counter back to its start.
    e0 = edges_a;
    for (int k = 0; k < 256; k++) begin
      dip = ~dip;
      ticks(6);
    end
    ticks(8);
    chk("wrap_edges", edges_a, e0);
    chk("wrap_led", led_a, dip);

    // Random hold lengths around the debounce threshold, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      dip = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 40) == 0);
      ticks($urandom_range(1, 7));
      rst = 1'b0;
    end
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
